seven_seg_capture: RTL and testbench

Receive-side counterpart of the two-digit multiplexed seven-segment driver. It samples the time-multiplexed `segment_in` bus on each strobe pulse and tracks the upper/lower digit phase. It decodes each 7-bit pattern back to a 4-bit hex nibble and presents the reconstructed byte with a one-cycle valid pulse. Placed wherever a board-level or loopback path must recover display data, e.g. self-checking display paths and bench monitors.

---
 rtl/seven_seg_capture.sv | 121 ++++++++++++
 tb/tb_seven_seg_capture.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: recovers a hex byte from a strobed, two-digit multiplexed seven-segment bus.
module seven_seg_capture #(
    parameter int TIMEOUT = 40000,
    parameter int TBITS   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segment_in,
    input  logic       strobe_in,
    output logic [3:0] hex_hi,
    output logic [3:0] hex_lo,
    output logic       pair_valid,
    output logic       pattern_err,
    output logic       link_lost,
    output logic [7:0] err_count
);
    typedef enum logic {WAIT_HI, WAIT_LO} state_t;
    localparam logic [TBITS-1:0] TMAX  = TBITS'(TIMEOUT);
    localparam logic [TBITS-1:0] TLAST = TBITS'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             strobe_q;
    logic [TBITS-1:0] cnt_q, cnt_d;
    logic [3:0]       pend_q, pend_d;
    logic             pend_err_q, pend_err_d;
    logic [3:0]       hex_hi_q, hex_hi_d, hex_lo_q, hex_lo_d;
    logic             pair_valid_q, pair_valid_d;
    logic             pattern_err_q, pattern_err_d;
    logic             link_lost_q, link_lost_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             ev, timeout, capture_hi, pair, pair_err;
    logic [3:0]       nib;
    logic             nib_err;

    always_comb begin
        nib_err = 1'b0;
        case (segment_in)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: begin
                nib     = 4'h0;
                nib_err = 1'b1;
            end
        endcase
    end

    // timeout marks the edge on which the counter arrives at TIMEOUT; a capture on that edge wins
    assign ev      = strobe_in & ~strobe_q;
    assign timeout = ~ev & (cnt_q >= TLAST);
    assign cnt_d   = ev ? '0 : (cnt_q == TMAX ? cnt_q : cnt_q + TBITS'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_HI;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = ev ? (state_q == WAIT_HI ? WAIT_LO : WAIT_HI) : (timeout ? WAIT_HI : state_q);
    end

    always_comb begin
        capture_hi    = ev & (state_q == WAIT_HI);
        pair          = ev & (state_q == WAIT_LO);
        pair_err      = pend_err_q | nib_err;
        pend_d        = capture_hi ? nib : (timeout ? 4'h0 : pend_q);
        pend_err_d    = capture_hi ? nib_err : (~timeout & pend_err_q);
        hex_hi_d      = pair ? pend_q : hex_hi_q;
        hex_lo_d      = pair ? nib : hex_lo_q;
        pattern_err_d = pair ? pair_err : pattern_err_q;
        pair_valid_d  = pair;
        err_count_d   = (pair & pair_err & (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
        link_lost_d   = ~ev & (link_lost_q | timeout);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q      <= 1'b1;
            cnt_q         <= '0;
            pend_q        <= 4'h0;
            pend_err_q    <= 1'b0;
            hex_hi_q      <= 4'h0;
            hex_lo_q      <= 4'h0;
            pair_valid_q  <= 1'b0;
            pattern_err_q <= 1'b0;
            link_lost_q   <= 1'b0;
            err_count_q   <= 8'h00;
        end else begin
            strobe_q      <= strobe_in;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            pend_err_q    <= pend_err_d;
            hex_hi_q      <= hex_hi_d;
            hex_lo_q      <= hex_lo_d;
            pair_valid_q  <= pair_valid_d;
            pattern_err_q <= pattern_err_d;
            link_lost_q   <= link_lost_d;
            err_count_q   <= err_count_d;
        end
    end

    assign hex_hi      = hex_hi_q;
    assign hex_lo      = hex_lo_q;
    assign pair_valid  = pair_valid_q;
    assign pattern_err = pattern_err_q;
    assign link_lost   = link_lost_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: randomized strobe traffic checked against an event-level model of the receiver.
module tb_seven_seg_capture;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] segment_in = 7'h00;
    logic       strobe_in = 1'b1;
    logic [3:0] hex_hi, hex_lo;
    logic       pair_valid, pattern_err, link_lost;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    seven_seg_capture #(.TIMEOUT(TO), .TBITS(6)) dut (
        .clk(clk), .rst(rst), .segment_in(segment_in), .strobe_in(strobe_in),
        .hex_hi(hex_hi), .hex_lo(hex_lo), .pair_valid(pair_valid),
        .pattern_err(pattern_err), .link_lost(link_lost), .err_count(err_count)
    );

    int total = 0;
    int bad = 0;
    int pv_seen = 0;
    byte unsigned tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int m_hi = 0, m_lo = 0, m_err = 0, m_pv = 0, m_lost = 0, m_cnt = 0, since = 0;
    bit m_prev = 1'b1;
    bit m_ok = 1'b0;
    int pend_q [$];

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (tab[i] == {1'b0, p}) return i;
        return 16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Event-level model: a pair is the next capture after an upper digit, unless TO idle edges intervened
    initial begin : model
        int d, p, nib;
        bit ev, e;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_prev = 1'b1; since = 0; pend_q.delete();
                m_hi = 0; m_lo = 0; m_err = 0; m_pv = 0; m_lost = 0; m_cnt = 0;
            end else begin
                ev = strobe_in && !m_prev;
                m_prev = strobe_in;
                m_pv = 0;
                if (ev) begin
                    d = decode(segment_in);
                    e = (d > 15);
                    nib = e ? 0 : d;
                    if (pend_q.size() == 0) pend_q.push_back((int'(e) << 4) | nib);
                    else begin
                        p = pend_q.pop_front();
                        m_hi = p & 15;
                        m_lo = nib;
                        m_err = ((p >> 4) & 1) | int'(e);
                        m_pv = 1;
                        if (m_err != 0 && m_cnt < 255) m_cnt++;
                    end
                    since = 0;
                    m_lost = 0;
                end else begin
                    since++;
                    if (since >= TO) begin
                        m_lost = 1;
                        pend_q.delete();
                    end
                end
            end
            m_ok = 1'b1;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_ok) begin
                check("hex_hi", 32'(hex_hi), 32'(m_hi));
                check("hex_lo", 32'(hex_lo), 32'(m_lo));
                check("pair_valid", 32'(pair_valid), 32'(m_pv));
                check("pattern_err", 32'(pattern_err), 32'(m_err));
                check("link_lost", 32'(link_lost), 32'(m_lost));
                check("err_count", 32'(err_count), 32'(m_cnt));
                if (pair_valid === 1'b1) pv_seen++;
            end
        end
    end

    task automatic pulse(input logic [6:0] pat, input int w, input int gap);
        segment_in = pat;
        strobe_in = 1'b1;
        repeat (w) @(negedge clk);
        strobe_in = 1'b0;
        segment_in = 7'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic pin(input logic [3:0] hi, input logic [3:0] lo, input logic err, input int pvs);
        #1;
        check("lit_hex_hi", 32'(hex_hi), 32'(hi));
        check("lit_hex_lo", 32'(hex_lo), 32'(lo));
        check("lit_pattern_err", 32'(pattern_err), 32'(err));
        check("lit_pair_count", 32'(pv_seen), 32'(pvs));
    endtask

    initial begin : stim
        logic [6:0] pat;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hex_hi", 32'(hex_hi), 32'd0);
        check("rst_pair_valid", 32'(pair_valid), 32'd0);
        check("rst_link_lost", 32'(link_lost), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        strobe_in = 1'b0;
        @(negedge clk);
        pulse(7'h66, 1, 30);
        pulse(7'h4F, 1, 2);
        pin(4'h4, 4'h3, 1'b0, 1);
        check("lit_err_count0", 32'(err_count), 32'd0);
        pulse(7'h00, 1, 2);
        pulse(7'h71, 1, 2);
        pin(4'h0, 4'hF, 1'b1, 2);
        check("lit_err_count1", 32'(err_count), 32'd1);
        pulse(7'h06, 1, TO + 10);
        #1;
        check("lit_link_lost", 32'(link_lost), 32'd1);
        pulse(7'h5B, 1, 1);
        #1;
        check("lit_link_clear", 32'(link_lost), 32'd0);
        pulse(7'h7F, 1, 2);
        pin(4'h2, 4'h8, 1'b0, 3);
        pulse(7'h3F, 5, 3);
        pulse(7'h06, 5, 3);
        pin(4'h0, 4'h1, 1'b0, 4);
        pulse(7'h77, 1, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse(7'h39, 1, 2);
        pulse(7'h5E, 1, 2);
        pin(4'hC, 4'hD, 1'b0, 5);
        pulse(7'h6D, 1, TO - 1);
        pulse(7'h7D, 1, 2);
        pin(4'h5, 4'h6, 1'b0, 6);
        pulse(7'h07, 1, TO);
        pulse(7'h6F, 1, 2);
        pin(4'h5, 4'h6, 1'b0, 6);
        pulse(7'h79, 1, 2);
        pin(4'h9, 4'hE, 1'b0, 7);
        repeat (300) begin
            pulse(7'h00, 1, 1);
            pulse(7'(tab[$urandom_range(0, 15)]), 1, 1);
        end
        #1;
        check("lit_err_sat", 32'(err_count), 32'd255);
        repeat (600) begin
            pat = ($urandom_range(0, 3) != 0) ? 7'(tab[$urandom_range(0, 15)]) : 7'($urandom);
            pulse(pat, $urandom_range(1, 4), $urandom_range(1, 70));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
